// File: rtl/seg_mux_capture.sv
// Receive side of a 4-digit multiplexed 7-segment bus: glitch-filtered capture, hex decode, staleness tracking.
// Optional build macro BLANK_DETECT_EN adds a per-digit Blank output for all-off captures.
module seg_mux_capture #(
    parameter int unsigned SETTLE_CYCLES  = 1000,
    parameter int unsigned TIMEOUT_CYCLES = 2000000,
    parameter int unsigned TIMEOUT_W      = 22
) (
    input  logic        Clock,
    input  logic        Reset,
    input  logic [3:0]  AnodeN,
    input  logic [6:0]  SegBus,
    output logic [27:0] Segs,
    output logic [15:0] Hex,
    output logic [3:0]  HexValid,
    output logic [3:0]  Stale,
`ifdef BLANK_DETECT_EN
    output logic [3:0]  Blank,
`endif
    output logic [3:0]  Updated
);

    localparam int unsigned NUM_DIGITS = 4;
    localparam int unsigned SEG_W      = 7;
    localparam int unsigned NIB_W      = 4;
    localparam int unsigned CNT_W      = 16;
    localparam int unsigned IDX_W      = 2;

    // Counter value one step before the capture edge.
    localparam logic [CNT_W-1:0]     SETTLE_PRE = CNT_W'(SETTLE_CYCLES - 2);
    localparam logic [TIMEOUT_W-1:0] AGE_MAX    = TIMEOUT_W'(TIMEOUT_CYCLES);

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_SETTLING = 2'd1,
        ST_CAPTURED = 2'd2
    } state_e;

    function automatic logic an_is_onehot(input logic [3:0] an);
        return (an == 4'b1110) || (an == 4'b1101) || (an == 4'b1011) || (an == 4'b0111);
    endfunction

    function automatic logic [IDX_W-1:0] an_index(input logic [3:0] an);
        logic [IDX_W-1:0] idx;
        case (an)
            4'b1101: idx = 2'd1;
            4'b1011: idx = 2'd2;
            4'b0111: idx = 2'd3;
            default: idx = 2'd0;
        endcase
        return idx;
    endfunction

    // Returns {legal, nibble}; illegal patterns decode to 0.
    function automatic logic [NIB_W:0] decode_glyph(input logic [SEG_W-1:0] s);
        logic [NIB_W:0] r;
        case (s)
            7'b0000001: r = {1'b1, 4'h0};
            7'b1001111: r = {1'b1, 4'h1};
            7'b0010010: r = {1'b1, 4'h2};
            7'b0000110: r = {1'b1, 4'h3};
            7'b1001100: r = {1'b1, 4'h4};
            7'b0100100: r = {1'b1, 4'h5};
            7'b0100000: r = {1'b1, 4'h6};
            7'b0001111: r = {1'b1, 4'h7};
            7'b0000000: r = {1'b1, 4'h8};
            7'b0000100: r = {1'b1, 4'h9};
            7'b0001000: r = {1'b1, 4'hA};
            7'b1100000: r = {1'b1, 4'hB};
            7'b0110001: r = {1'b1, 4'hC};
            7'b1000010: r = {1'b1, 4'hD};
            7'b0110000: r = {1'b1, 4'hE};
            7'b0111000: r = {1'b1, 4'hF};
            default:    r = {1'b0, 4'h0};
        endcase
        return r;
    endfunction

    logic [3:0]       an_q, an_d, an_prev_q, an_prev_d;
    logic [SEG_W-1:0] seg_q, seg_d, seg_prev_q, seg_prev_d;
    state_e           state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             capture;

    logic             an_onehot, an_chg, seg_chg;
    logic [IDX_W-1:0] an_idx;

    assign an_onehot = an_is_onehot(an_q);
    assign an_idx    = an_index(an_q);
    assign an_chg    = (an_q != an_prev_q);
    assign seg_chg   = (seg_q != seg_prev_q);

    // Input register plus one-deep history for change detection.
    always_comb begin
        an_d       = AnodeN;
        seg_d      = SegBus;
        an_prev_d  = an_q;
        seg_prev_d = seg_q;
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            an_q       <= '1;
            seg_q      <= '1;
            an_prev_q  <= '1;
            seg_prev_q <= '1;
            state_q    <= ST_IDLE;
            idx_q      <= '0;
            cnt_q      <= '0;
        end else begin
            an_q       <= an_d;
            seg_q      <= seg_d;
            an_prev_q  <= an_prev_d;
            seg_prev_q <= seg_prev_d;
            state_q    <= state_d;
            idx_q      <= idx_d;
            cnt_q      <= cnt_d;
        end
    end

    // Settle FSM: an anode change always restarts; a segment change restarts the same digit.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        capture = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (an_onehot) begin
                    state_d = ST_SETTLING;
                    idx_d   = an_idx;
                    cnt_d   = '0;
                end
            end
            ST_SETTLING: begin
                if (an_chg) begin
                    cnt_d = '0;
                    if (an_onehot) begin
                        state_d = ST_SETTLING;
                        idx_d   = an_idx;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else if (seg_chg) begin
                    cnt_d = '0;
                end else if (cnt_q == SETTLE_PRE) begin
                    cnt_d   = cnt_q + CNT_W'(1);
                    capture = 1'b1;
                    state_d = ST_CAPTURED;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_CAPTURED: begin
                if (an_chg) begin
                    cnt_d = '0;
                    if (an_onehot) begin
                        state_d = ST_SETTLING;
                        idx_d   = an_idx;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else if (seg_chg) begin
                    state_d = ST_SETTLING;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    logic [27:0]          segs_q, segs_d;
    logic [15:0]          hex_q, hex_d;
    logic [3:0]           hv_q, hv_d;
    logic [3:0]           stale_q, stale_d;
    logic [3:0]           upd_q, upd_d;
    logic [TIMEOUT_W-1:0] age_q [NUM_DIGITS];
    logic [TIMEOUT_W-1:0] age_d [NUM_DIGITS];
    logic [3:0]           cap_sel;
    logic [NIB_W:0]       glyph;
`ifdef BLANK_DETECT_EN
    logic [3:0]           blank_q, blank_d;
`endif

    assign cap_sel = capture ? (4'b0001 << idx_q) : 4'b0000;
    assign glyph   = decode_glyph(seg_q);

    // Per-digit capture and aging; a capture takes precedence over a same-cycle timeout.
    always_comb begin
        segs_d  = segs_q;
        hex_d   = hex_q;
        hv_d    = hv_q;
        stale_d = stale_q;
        upd_d   = '0;
`ifdef BLANK_DETECT_EN
        blank_d = blank_q;
`endif
        for (int i = 0; i < NUM_DIGITS; i++) begin
            age_d[i] = age_q[i];
            if (cap_sel[i]) begin
                segs_d[SEG_W*i +: SEG_W] = seg_q;
                hex_d[NIB_W*i +: NIB_W]  = glyph[NIB_W-1:0];
                hv_d[i]                  = glyph[NIB_W];
                stale_d[i]               = 1'b0;
                age_d[i]                 = '0;
                upd_d[i]                 = 1'b1;
`ifdef BLANK_DETECT_EN
                blank_d[i]               = (seg_q == 7'h7F);
`endif
            end else begin
                if (age_q[i] != AGE_MAX) begin
                    age_d[i] = age_q[i] + TIMEOUT_W'(1);
                end
                if (age_d[i] == AGE_MAX) begin
                    stale_d[i] = 1'b1;
                    hv_d[i]    = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            segs_q  <= '1;
            hex_q   <= '0;
            hv_q    <= '0;
            stale_q <= '1;
            upd_q   <= '0;
`ifdef BLANK_DETECT_EN
            blank_q <= '0;
`endif
            for (int i = 0; i < NUM_DIGITS; i++) begin
                age_q[i] <= '0;
            end
        end else begin
            segs_q  <= segs_d;
            hex_q   <= hex_d;
            hv_q    <= hv_d;
            stale_q <= stale_d;
            upd_q   <= upd_d;
`ifdef BLANK_DETECT_EN
            blank_q <= blank_d;
`endif
            for (int i = 0; i < NUM_DIGITS; i++) begin
                age_q[i] <= age_d[i];
            end
        end
    end

    assign Segs     = segs_q;
    assign Hex      = hex_q;
    assign HexValid = hv_q;
    assign Stale    = stale_q;
    assign Updated  = upd_q;
`ifdef BLANK_DETECT_EN
    assign Blank    = blank_q;
`endif

endmodule

// File: tb/tb_seg_mux_capture.sv
// Directed bench for seg_mux_capture: two instances share the bus, one with a short timeout for aging checks.
module tb_seg_mux_capture;

    logic        Clock;
    logic        Reset;
    logic [3:0]  AnodeN;
    logic [6:0]  SegBus;

    logic [27:0] a_segs, b_segs;
    logic [15:0] a_hex, b_hex;
    logic [3:0]  a_hv, b_hv, a_stale, b_stale, a_upd, b_upd;
`ifdef BLANK_DETECT_EN
    logic [3:0]  a_blank, b_blank;
`endif

    int n_cmp = 0;
    int n_err = 0;
    int a_upd_cnt [4];
    int base [4];

    seg_mux_capture #(.SETTLE_CYCLES(4), .TIMEOUT_CYCLES(1000), .TIMEOUT_W(10)) dut_a (
        .Clock(Clock), .Reset(Reset), .AnodeN(AnodeN), .SegBus(SegBus),
        .Segs(a_segs), .Hex(a_hex), .HexValid(a_hv), .Stale(a_stale),
`ifdef BLANK_DETECT_EN
        .Blank(a_blank),
`endif
        .Updated(a_upd)
    );

    seg_mux_capture #(.SETTLE_CYCLES(4), .TIMEOUT_CYCLES(20), .TIMEOUT_W(5)) dut_b (
        .Clock(Clock), .Reset(Reset), .AnodeN(AnodeN), .SegBus(SegBus),
        .Segs(b_segs), .Hex(b_hex), .HexValid(b_hv), .Stale(b_stale),
`ifdef BLANK_DETECT_EN
        .Blank(b_blank),
`endif
        .Updated(b_upd)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    // Count Updated pulses of instance A on the falling edge.
    initial for (int i = 0; i < 4; i++) a_upd_cnt[i] = 0;
    always @(negedge Clock) begin
        for (int i = 0; i < 4; i++) begin
            if (a_upd[i]) a_upd_cnt[i] <= a_upd_cnt[i] + 1;
        end
    end

    task automatic step();
        @(posedge Clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        Reset  = 1'b1;
        AnodeN = 4'b1111;
        SegBus = 7'b1111111;
        step();
        step();
        chk("rst_segs",  32'(a_segs),  32'h0FFF_FFFF);
        chk("rst_hex",   32'(a_hex),   32'h0);
        chk("rst_hv",    32'(a_hv),    32'h0);
        chk("rst_stale", 32'(a_stale), 32'hF);
        chk("rst_upd",   32'(a_upd),   32'h0);
        Reset = 1'b0;

        // Single digit '0' on digit 0: capture on the 5th clock.
        AnodeN = 4'b1110;
        SegBus = 7'b0000001;
        repeat (4) step();
        chk("t1_upd_early", 32'(a_upd), 32'h0);
        step();
        chk("t1_upd",   32'(a_upd),        32'h1);
        chk("t1_hex0",  32'(a_hex[3:0]),   32'h0);
        chk("t1_hv",    32'(a_hv),         32'h1);
        chk("t1_stale", 32'(a_stale),      32'hE);
        chk("t1_segs0", 32'(a_segs[6:0]),  32'h01);
        step();
        chk("t1_upd_off", 32'(a_upd), 32'h0);

        // Rotation: digit0 '3', digit1 '7', digit2 'b', digit3 'A'.
        for (int i = 0; i < 4; i++) base[i] = a_upd_cnt[i];
        SegBus = 7'b0000110;
        repeat (10) step();
        AnodeN = 4'b1101; SegBus = 7'b0001111;
        repeat (10) step();
        AnodeN = 4'b1011; SegBus = 7'b1100000;
        repeat (10) step();
        AnodeN = 4'b0111; SegBus = 7'b0001000;
        repeat (10) step();
        chk("t2_hex",   32'(a_hex),   32'hAB73);
        chk("t2_hv",    32'(a_hv),    32'hF);
        chk("t2_stale", 32'(a_stale), 32'h0);
        chk("t2_pulses0", 32'(a_upd_cnt[0] - base[0]), 32'd1);
        chk("t2_pulses1", 32'(a_upd_cnt[1] - base[1]), 32'd1);
        chk("t2_pulses2", 32'(a_upd_cnt[2] - base[2]), 32'd1);
        chk("t2_pulses3", 32'(a_upd_cnt[3] - base[3]), 32'd1);

        // Glitching segments on digit 1 never settle; then '5' held.
        base[1] = a_upd_cnt[1];
        AnodeN = 4'b1101;
        for (int k = 0; k < 6; k++) begin
            SegBus = (k % 2 == 0) ? 7'b1001111 : 7'b0010010;
            repeat (2) step();
        end
        chk("t3_no_cap",  32'(a_upd_cnt[1] - base[1]), 32'd0);
        chk("t3_hex_old", 32'(a_hex[7:4]), 32'h7);
        SegBus = 7'b0100100;
        repeat (4) step();
        chk("t3_upd_early", 32'(a_upd), 32'h0);
        step();
        chk("t3_upd",  32'(a_upd),       32'h2);
        chk("t3_hex1", 32'(a_hex[7:4]),  32'h5);
        step();
        chk("t3_pulses", 32'(a_upd_cnt[1] - base[1]), 32'd1);

        // Non-one-hot anodes leave everything untouched.
        for (int i = 0; i < 4; i++) base[i] = a_upd_cnt[i];
        AnodeN = 4'b1100; SegBus = 7'b0000000;
        repeat (8) step();
        AnodeN = 4'b1111;
        repeat (8) step();
        chk("t4_segs", 32'(a_segs), 32'({7'b0001000, 7'b1100000, 7'b0100100, 7'b0000110}));
        chk("t4_hex",  32'(a_hex),  32'hAB53);
        chk("t4_hv",   32'(a_hv),   32'hF);
        chk("t4_no_pulse", 32'((a_upd_cnt[0] - base[0]) + (a_upd_cnt[1] - base[1])
                               + (a_upd_cnt[2] - base[2]) + (a_upd_cnt[3] - base[3])), 32'd0);
        AnodeN = 4'b0111; SegBus = 7'b1111110;
        repeat (4) step();
        chk("t4_upd_early", 32'(a_upd), 32'h0);
        step();
        chk("t4_segs3", 32'(a_segs[27:21]), 32'h7E);
        chk("t4_hv3",   32'(a_hv),          32'h7);
        chk("t4_hex3",  32'(a_hex),         32'h0B53);
        chk("t4_upd",   32'(a_upd),         32'h8);

        // Aging on the short-timeout instance: digit 2 'E'.
        AnodeN = 4'b1011; SegBus = 7'b0110000;
        repeat (5) step();
        chk("t5_cap", 32'(b_upd), 32'h4);
        AnodeN = 4'b1110;
        repeat (19) step();
        chk("t5_stale19", 32'(b_stale[2]), 32'h0);
        chk("t5_hv19",    32'(b_hv[2]),    32'h1);
        step();
        chk("t5_stale20", 32'(b_stale[2]),   32'h1);
        chk("t5_hv20",    32'(b_hv[2]),      32'h0);
        chk("t5_segs2",   32'(b_segs[20:14]), 32'h30);
        chk("t5_hex2",    32'(b_hex[11:8]),   32'hE);
        // Re-capture 'F', then land the next capture exactly on the timeout cycle.
        AnodeN = 4'b1011; SegBus = 7'b0111000;
        repeat (5) step();
        chk("t5_recap",       32'(b_upd[2]),    32'h1);
        chk("t5_recap_stale", 32'(b_stale[2]),  32'h0);
        chk("t5_recap_hex",   32'(b_hex[11:8]), 32'hF);
        AnodeN = 4'b1110;
        repeat (15) step();
        AnodeN = 4'b1011;
        repeat (4) step();
        chk("t5_pre_stale", 32'(b_stale[2]), 32'h0);
        step();
        chk("t5_win_upd",   32'(b_upd),      32'h4);
        chk("t5_win_stale", 32'(b_stale[2]), 32'h0);
        chk("t5_win_hv",    32'(b_hv[2]),    32'h1);

        // Reset in the middle of a settle.
        AnodeN = 4'b1101; SegBus = 7'b0000100;
        repeat (3) step();
        Reset = 1'b1;
        step();
        chk("t6_segs",   32'(a_segs),  32'h0FFF_FFFF);
        chk("t6_hex",    32'(a_hex),   32'h0);
        chk("t6_hv",     32'(a_hv),    32'h0);
        chk("t6_stale",  32'(a_stale), 32'hF);
        chk("t6_upd",    32'(a_upd),   32'h0);
        chk("t6_bstale", 32'(b_stale), 32'hF);
        Reset = 1'b0;
        repeat (4) step();
        chk("t6_upd_early", 32'(a_upd), 32'h0);
        step();
        chk("t6_upd2",  32'(a_upd),   32'h2);
        chk("t6_hex2",  32'(a_hex),   32'h0090);
        chk("t6_hv2",   32'(a_hv),    32'h2);
        chk("t6_stale2", 32'(a_stale), 32'hD);
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
